// File: rtl/train_pkg.sv
// Shared types and widths for the train speed measurement blocks.
package train_pkg;

  localparam int TIME_W  = 19;
  localparam int SPEED_W = 16;
  localparam int NUM_W   = 32;

  localparam logic [SPEED_W-1:0] SPEED_SAT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DIVIDE,
    DONE
  } state_t;

endpackage

// File: rtl/div_serial.sv
// Serial restoring divider: one quotient bit per clock, W clocks after start.
// done is high during the cycle whose rising edge produces the final quotient bit.
module div_serial
  import train_pkg::*;
#(
  parameter int W = NUM_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0]  quo_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  dvs_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;

  logic [W:0] shifted;
  logic [W:0] trial;
  logic       fits;

  // Bring down the next dividend bit and trial-subtract the divisor.
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    trial   = shifted - {1'b0, dvs_q};
    fits    = ~trial[W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      rem_q <= fits ? trial[W-1:0] : shifted[W-1:0];
      quo_q <= {quo_q[W-2:0], fits};
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST) run_q <= 1'b0;
    end
  end

  assign done      = run_q && (cnt_q == LAST);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/speed_calc.sv
// Train speed from sensor-to-sensor time: speed = DIST_MM*1000 / time_ms, saturated to 16 bits.
// Define SPEED_CALC_OVERSPEED_EN to add the overspeed output compared against SPEED_LIMIT.
module speed_calc
  import train_pkg::*;
#(
  parameter int DIST_MM     = 500,
  parameter int SPEED_LIMIT = 1500
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [TIME_W-1:0]  time_ms,
  output logic [SPEED_W-1:0] speed,
  output logic               valid,
  output logic               busy,
  output logic               err
`ifdef SPEED_CALC_OVERSPEED_EN
  ,
  output logic               overspeed
`endif
);

  localparam logic [NUM_W-1:0] NUMERATOR = NUM_W'(DIST_MM * 1000);

  if (DIST_MM < 1 || DIST_MM > 4095 || SPEED_LIMIT < 0) begin : g_bad_cfg
    $error("speed_calc: DIST_MM must be 1..4095 and SPEED_LIMIT non-negative");
  end

  function automatic logic [SPEED_W-1:0] sat_speed(input logic [NUM_W-1:0] q);
    return (|q[NUM_W-1:SPEED_W]) ? SPEED_SAT : q[SPEED_W-1:0];
  endfunction

  state_t state_q, state_d;
  logic   en_q;
  logic   zero_q;
  logic   start_div;
  logic   div_done;
  logic [NUM_W-1:0]   quotient;
  logic [NUM_W-1:0]   div_rem_unused;
  logic [SPEED_W-1:0] speed_d;

  div_serial #(.W(NUM_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_div),
    .dividend (NUMERATOR),
    .divisor  (NUM_W'(time_ms)),
    .done     (div_done),
    .quotient (quotient),
    .remainder(div_rem_unused)
  );

  // Only a falling edge seen in IDLE starts a measurement; others are dropped.
  always_comb begin
    state_d   = state_q;
    start_div = 1'b0;
    case (state_q)
      IDLE:    if (en_q && !en) state_d = CAPTURE;
      CAPTURE: begin
        if (time_ms == '0) begin
          state_d = DONE;
        end else begin
          start_div = 1'b1;
          state_d   = DIVIDE;
        end
      end
      DIVIDE:  if (div_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    speed_d = zero_q ? SPEED_SAT : sat_speed(quotient);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      zero_q  <= 1'b0;
      speed   <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en;
      valid   <= 1'b0;
      if (state_q == CAPTURE) zero_q <= (time_ms == '0);
      if (state_q == DONE) begin
        speed <= speed_d;
        err   <= zero_q;
        valid <= 1'b1;
      end
    end
  end

  assign busy = (state_q == CAPTURE) || (state_q == DIVIDE);

`ifdef SPEED_CALC_OVERSPEED_EN
  localparam logic [SPEED_W-1:0] LIMIT = SPEED_W'(SPEED_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overspeed <= 1'b0;
    end else if (state_q == DONE) begin
      overspeed <= !zero_q && (speed_d > LIMIT);
    end
  end
`endif

endmodule

// File: tb/tb_speed_calc.sv
// Directed bench for speed_calc (DIST_MM=500, SPEED_LIMIT=1500); table vectors plus corner sequences.
module tb_speed_calc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [18:0] time_ms;
  logic [15:0] speed;
  logic        valid;
  logic        busy;
  logic        err;
`ifdef SPEED_CALC_OVERSPEED_EN
  logic        overspeed;
`endif

  int total = 0;
  int bad   = 0;

  speed_calc #(.DIST_MM(500), .SPEED_LIMIT(1500)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .time_ms  (time_ms),
    .speed    (speed),
    .valid    (valid),
    .busy     (busy),
    .err      (err)
`ifdef SPEED_CALC_OVERSPEED_EN
    ,
    .overspeed(overspeed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] t;
    logic [15:0] spd;
    logic        er;
    logic        ovs;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic get_ovs();
`ifdef SPEED_CALC_OVERSPEED_EN
    return overspeed;
`else
    return 1'b0;
`endif
  endfunction

  // Produces a falling edge of en; returns after the detecting edge k has occurred.
  task automatic start_meas(input logic [18:0] t);
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0; time_ms = t;
    @(posedge clk);
  endtask

  task automatic measure(input logic [18:0] t, output logic [15:0] spd, output logic er,
                         output logic ovs, output int lat, output logic bsy);
    start_meas(t);
    lat = -1;
    bsy = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n == 1) bsy = busy;
      if (valid) begin
        lat = n;
        break;
      end
    end
    spd = speed;
    er  = err;
    ovs = get_ovs();
  endtask

  initial begin
    logic [15:0] spd;
    logic        er, ovs, bsy;
    int          lat, vcnt;
    logic [15:0] vspd;

    vecs[0]  = '{19'd250,    16'd2000,  1'b0, 1'b1, 34};
    vecs[1]  = '{19'd0,      16'hFFFF,  1'b1, 1'b0, 2};
    vecs[2]  = '{19'd1,      16'hFFFF,  1'b0, 1'b1, 34};
    vecs[3]  = '{19'd524287, 16'd0,     1'b0, 1'b0, 34};
    vecs[4]  = '{19'd400,    16'd1250,  1'b0, 1'b0, 34};
    vecs[5]  = '{19'd8,      16'd62500, 1'b0, 1'b1, 34};
    vecs[6]  = '{19'd7,      16'hFFFF,  1'b0, 1'b1, 34};
    vecs[7]  = '{19'd333,    16'd1501,  1'b0, 1'b1, 34};
    vecs[8]  = '{19'd334,    16'd1497,  1'b0, 1'b0, 34};
    vecs[9]  = '{19'd1000,   16'd500,   1'b0, 1'b0, 34};
    vecs[10] = '{19'd499999, 16'd1,     1'b0, 1'b0, 34};

    // Reset state, with en held high so a release-time fall must not be taken.
    rst_n = 1'b0; en = 1'b1; time_ms = 19'd0;
    #1;
    check("reset_speed", speed, 0);
    check("reset_valid", valid, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err, 0);
    check("reset_ovs", get_ovs(), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; en = 1'b0;
    vcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (valid || busy) vcnt++;
    end
    check("release_no_start", vcnt, 0);

    foreach (vecs[i]) begin
      measure(vecs[i].t, spd, er, ovs, lat, bsy);
      check($sformatf("lat_t%0d", vecs[i].t), lat, vecs[i].lat);
      check($sformatf("speed_t%0d", vecs[i].t), spd, vecs[i].spd);
      check($sformatf("err_t%0d", vecs[i].t), er, vecs[i].er);
      check($sformatf("busy_t%0d", vecs[i].t), bsy, vecs[i].lat == 34);
`ifdef SPEED_CALC_OVERSPEED_EN
      check($sformatf("ovs_t%0d", vecs[i].t), ovs, vecs[i].ovs);
`endif
      @(posedge clk); #1;
      check($sformatf("pulse_end_t%0d", vecs[i].t), valid, 0);
      check($sformatf("hold_t%0d", vecs[i].t), speed, vecs[i].spd);
      check($sformatf("hold_err_t%0d", vecs[i].t), err, vecs[i].er);
    end

    // Extra falls and rises plus a time_ms change during DIVIDE are ignored.
    start_meas(19'd250);
    vcnt = 0; lat = -1; vspd = 16'd0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (valid) begin
        vcnt++;
        vspd = speed;
        if (lat < 0) lat = n;
      end
      if (n == 8)  en = 1'b1;
      if (n == 9)  en = 1'b0;
      if (n == 12) time_ms = 19'd1;
      if (n == 20) en = 1'b1;
      if (n == 21) en = 1'b0;
    end
    check("busy_fall_count", vcnt, 1);
    check("busy_fall_lat", lat, 34);
    check("busy_fall_speed", vspd, 2000);

    // A fall seen on the DONE edge (k+34) must not start a new measurement.
    start_meas(19'd400);
    vcnt = 0; vspd = 16'd0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk); #1;
      if (valid) begin
        vcnt++;
        vspd = speed;
      end
      if (n == 32) en = 1'b1;
      if (n == 33) en = 1'b0;
    end
    check("done_fall_count", vcnt, 1);
    check("done_fall_speed", vspd, 1250);

    // Reset mid-DIVIDE clears everything and abandons the result.
    start_meas(19'd250);
    repeat (14) @(posedge clk);
    #1;
    check("mid_div_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_speed", speed, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_ovs", get_ovs(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    vcnt = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (valid) vcnt++;
    end
    check("mid_rst_no_valid", vcnt, 0);

    // Normal operation resumes after the abandoned computation.
    measure(19'd250, spd, er, ovs, lat, bsy);
    check("post_rst_lat", lat, 34);
    check("post_rst_speed", spd, 2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
